// File: rtl/bp_pkg.sv
// Shared types for the branch predictor: direction counter encoding, BTB entry
// layout and the saturating counter helpers.
package bp_pkg;

    localparam int unsigned ADDR_W     = 10;
    localparam int unsigned ENTRIES    = 16;
    localparam int unsigned INDEX_BITS = $clog2(ENTRIES);
    localparam int unsigned TAG_W      = ADDR_W - INDEX_BITS - 2;

    typedef enum logic [1:0] {
        STRONG_NT = 2'b00,
        WEAK_NT   = 2'b01,
        WEAK_T    = 2'b10,
        STRONG_T  = 2'b11
    } ctr_e;

    typedef struct packed {
        logic              valid;
        logic [TAG_W-1:0]  tag;
        logic [ADDR_W-1:0] target;
        logic              jump;
    } btb_entry_t;

    function automatic ctr_e sat_inc(input ctr_e c);
        return (c == STRONG_T) ? STRONG_T : ctr_e'(c + 2'd1);
    endfunction

    function automatic ctr_e sat_dec(input ctr_e c);
        return (c == STRONG_NT) ? STRONG_NT : ctr_e'(c - 2'd1);
    endfunction

endpackage

// File: rtl/btb_table.sv
// Direct-mapped BTB + direction counter storage: async fetch read, async
// resolve-side read for tag check, one synchronous write, synchronous clear.
module btb_table
    import bp_pkg::*;
#(
    parameter int unsigned Entries = ENTRIES,
    localparam int unsigned IndexBits = $clog2(Entries)
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic [IndexBits-1:0] rd_idx_i,
    output btb_entry_t           rd_entry_o,
    output ctr_e                 rd_ctr_o,
    input  logic [IndexBits-1:0] chk_idx_i,
    output btb_entry_t           chk_entry_o,
    output ctr_e                 chk_ctr_o,
    input  logic                 wr_en_i,
    input  logic [IndexBits-1:0] wr_idx_i,
    input  btb_entry_t           wr_entry_i,
    input  ctr_e                 wr_ctr_i
);

    btb_entry_t entry_q [Entries];
    ctr_e       ctr_q   [Entries];

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            for (int unsigned i = 0; i < Entries; i++) begin
                entry_q[i] <= '0;
                ctr_q[i]   <= WEAK_NT;
            end
        end else if (wr_en_i) begin
            entry_q[wr_idx_i] <= wr_entry_i;
            ctr_q[wr_idx_i]   <= wr_ctr_i;
        end
    end

    assign rd_entry_o  = entry_q[rd_idx_i];
    assign rd_ctr_o    = ctr_q[rd_idx_i];
    assign chk_entry_o = entry_q[chk_idx_i];
    assign chk_ctr_o   = ctr_q[chk_idx_i];

endmodule

// File: rtl/branch_predictor_unit.sv
// Fetch-side next-PC prediction and execute-side resolution/training.
// Define BP_PERF_COUNTERS_EN to add branch and mispredict event counters.
module branch_predictor_unit
    import bp_pkg::*;
#(
    parameter int unsigned AddressWidth = 10,
    parameter int unsigned Entries      = 16
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic [AddressWidth-1:0] fetch_pc_i,
    output logic                    pred_taken_o,
    output logic [AddressWidth-1:0] pred_target_o,
    input  logic                    res_valid_i,
    input  logic [AddressWidth-1:0] res_pc_i,
    input  logic                    res_branch_i,
    input  logic                    res_jump_i,
    input  logic                    res_taken_i,
    input  logic [AddressWidth-1:0] res_target_i,
    input  logic                    res_pred_taken_i,
    input  logic [AddressWidth-1:0] res_pred_target_i,
    output logic                    mispredict_o,
    output logic [AddressWidth-1:0] redirect_pc_o
`ifdef BP_PERF_COUNTERS_EN
    ,
    output logic [31:0]             branch_count_o,
    output logic [31:0]             mispredict_count_o
`endif
);

    localparam int unsigned IndexBits = $clog2(Entries);

    // The entry struct is sized from the package, so the parameters must agree with it.
    if (AddressWidth < IndexBits + 3) begin : g_bad_width
        $error("AddressWidth must be at least IndexBits+3");
    end
    if ((1 << IndexBits) != Entries || Entries < 2) begin : g_bad_entries
        $error("Entries must be a power of two and at least 2");
    end
    if (AddressWidth != ADDR_W || Entries != ENTRIES) begin : g_pkg_mismatch
        $error("parameters must match bp_pkg ADDR_W/ENTRIES");
    end

    logic [IndexBits-1:0] fetch_idx, res_idx;
    logic [TAG_W-1:0]     fetch_tag, res_tag;
    btb_entry_t           fetch_entry, res_entry, wr_entry;
    ctr_e                 fetch_ctr, res_ctr, wr_ctr;
    logic                 fetch_hit, res_hit, wr_en;

    assign fetch_idx = fetch_pc_i[IndexBits+1:2];
    assign fetch_tag = fetch_pc_i[AddressWidth-1:IndexBits+2];
    assign res_idx   = res_pc_i[IndexBits+1:2];
    assign res_tag   = res_pc_i[AddressWidth-1:IndexBits+2];

    btb_table #(.Entries(Entries)) u_table (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .rd_idx_i   (fetch_idx),
        .rd_entry_o (fetch_entry),
        .rd_ctr_o   (fetch_ctr),
        .chk_idx_i  (res_idx),
        .chk_entry_o(res_entry),
        .chk_ctr_o  (res_ctr),
        .wr_en_i    (wr_en),
        .wr_idx_i   (res_idx),
        .wr_entry_i (wr_entry),
        .wr_ctr_i   (wr_ctr)
    );

    assign fetch_hit     = fetch_entry.valid && (fetch_entry.tag == fetch_tag);
    assign pred_taken_o  = fetch_hit && (fetch_entry.jump || fetch_ctr[1]);
    assign pred_target_o = pred_taken_o ? fetch_entry.target
                                        : fetch_pc_i + AddressWidth'(4);

    assign mispredict_o  = res_valid_i &&
                           ((res_taken_i != res_pred_taken_i) ||
                            (res_taken_i && (res_target_i != res_pred_target_i)));
    assign redirect_pc_o = res_taken_i ? res_target_i : res_pc_i + AddressWidth'(4);

    assign res_hit = res_entry.valid && (res_entry.tag == res_tag);

    // Jump wins when both class bits are set; a non-control-flow hit scrubs the alias.
    always_comb begin
        wr_en    = 1'b0;
        wr_entry = res_entry;
        wr_ctr   = res_ctr;
        if (res_valid_i) begin
            if (res_jump_i) begin
                wr_en    = 1'b1;
                wr_entry = '{valid: 1'b1, tag: res_tag, target: res_target_i, jump: 1'b1};
                wr_ctr   = STRONG_T;
            end else if (res_branch_i) begin
                if (res_hit) begin
                    wr_en  = 1'b1;
                    wr_ctr = res_taken_i ? sat_inc(res_ctr) : sat_dec(res_ctr);
                    if (res_taken_i) begin
                        wr_entry.target = res_target_i;
                    end
                end else if (res_taken_i) begin
                    wr_en    = 1'b1;
                    wr_entry = '{valid: 1'b1, tag: res_tag, target: res_target_i, jump: 1'b0};
                    wr_ctr   = WEAK_T;
                end
            end else if (res_hit) begin
                wr_en          = 1'b1;
                wr_entry.valid = 1'b0;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_ni && res_valid_i) begin
            assert (!(res_branch_i && res_jump_i))
            else $error("res_branch_i and res_jump_i asserted together");
        end
    end

`ifdef BP_PERF_COUNTERS_EN
    logic [31:0] branch_cnt_q, branch_cnt_d;
    logic [31:0] mispred_cnt_q, mispred_cnt_d;

    assign branch_cnt_d  = branch_cnt_q + 32'(res_valid_i && (res_branch_i || res_jump_i));
    assign mispred_cnt_d = mispred_cnt_q + 32'(mispredict_o);

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            branch_cnt_q  <= '0;
            mispred_cnt_q <= '0;
        end else begin
            branch_cnt_q  <= branch_cnt_d;
            mispred_cnt_q <= mispred_cnt_d;
        end
    end

    assign branch_count_o     = branch_cnt_q;
    assign mispredict_count_o = mispred_cnt_q;
`endif

endmodule
